// File: rtl/ov7670_emulator.sv
// OV7670-style DVP transmitter: emits PCLK/VSYNC/HREF/D in VGA YCbCr 4:2:2 timing
// from an internal test-pattern source, standing in for the physical sensor.
module ov7670_emulator #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int H_BLANK_BYTES = 288,
  parameter int V_SYNC_LINES  = 3,
  parameter int V_BACK_LINES  = 17,
  parameter int V_FRONT_LINES = 10,
  parameter int BOX_SIZE      = 32
) (
  input  logic       CLOCK_24,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  output logic       PCLK,
  output logic       VSYNC,
  output logic       HREF,
  output logic [7:0] D,
  output logic       frame_start,
  output logic       busy
);

  localparam int LINE_BYTES   = 2 * H_ACTIVE + H_BLANK_BYTES;
  localparam int ACTIVE_BYTES = 2 * H_ACTIVE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBACK,
    S_ACTIVE,
    S_VFRONT
  } state_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } ycc_t;

  localparam ycc_t C_RED    = '{y: 8'd76,  cb: 8'd85,  cr: 8'd255};
  localparam ycc_t C_GREEN  = '{y: 8'd150, cb: 8'd44,  cr: 8'd21};
  localparam ycc_t C_YELLOW = '{y: 8'd226, cb: 8'd1,   cr: 8'd149};
  localparam ycc_t C_BLUE   = '{y: 8'd29,  cb: 8'd255, cr: 8'd107};
  localparam ycc_t C_GRAY   = '{y: 8'd128, cb: 8'd128, cr: 8'd128};

  state_t      state_q, state_d;
  logic [10:0] byte_q, byte_d;
  logic [8:0]  line_q, line_d;
  logic [8:0]  last_line;
  logic        pclk_q;
  logic        slot;
  logic        start_frame;

  logic [1:0]  pat_q;
  logic [9:0]  box_x_q, box_y_q;

  logic [9:0]  px;
  logic        in_box;
  ycc_t        colour;
  logic        href_d;
  logic [7:0]  d_d;

  // The slot is the cycle in which pclk falls, so outputs settle half a PCLK
  // period before the receiver samples on the rising edge.
  assign slot = pclk_q;
  assign PCLK = pclk_q;

  always_comb begin
    last_line = 9'(V_FRONT_LINES - 1);
    case (state_q)
      S_VSYNC:  last_line = 9'(V_SYNC_LINES - 1);
      S_VBACK:  last_line = 9'(V_BACK_LINES - 1);
      S_ACTIVE: last_line = 9'(V_ACTIVE - 1);
      default:  last_line = 9'(V_FRONT_LINES - 1);
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case/if tree leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    line_d      = line_q;
    start_frame = 1'b0;
    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d     = S_VSYNC;
        byte_d      = '0;
        line_d      = '0;
        start_frame = 1'b1;
      end
    end else if (byte_q == 11'(LINE_BYTES - 1)) begin
      byte_d = '0;
      if (line_q == last_line) begin
        line_d = '0;
        case (state_q)
          S_VSYNC:  state_d = S_VBACK;
          S_VBACK:  state_d = S_ACTIVE;
          S_ACTIVE: state_d = S_VFRONT;
          default: begin
            // enable is only looked at here, so a frame always runs to the end.
            if (enable) begin
              state_d     = S_VSYNC;
              start_frame = 1'b1;
            end else begin
              state_d = S_IDLE;
            end
          end
        endcase
      end else begin
        line_d = line_q + 9'd1;
      end
    end else begin
      byte_d = byte_q + 11'd1;
    end
  end

  // Pixel for the byte being entered: x of the pair, or x+1 for the second Y.
  always_comb begin
    px     = {byte_d[10:2], byte_d[1] & byte_d[0]};
    in_box = ({1'b0, px} >= {1'b0, box_x_q})
          && ({1'b0, px} < ({1'b0, box_x_q} + 11'(BOX_SIZE)))
          && ({2'b00, line_d} >= {1'b0, box_y_q})
          && ({2'b00, line_d} < ({1'b0, box_y_q} + 11'(BOX_SIZE)));
    colour = C_GRAY;
    case (pat_q)
      2'd0: colour = '{y: px[7:0], cb: 8'd128, cr: 8'd128};
      2'd1: begin
        if (px < 10'd160)      colour = C_RED;
        else if (px < 10'd320) colour = C_GREEN;
        else if (px < 10'd480) colour = C_YELLOW;
        else                   colour = C_BLUE;
      end
      2'd2:    colour = in_box ? C_GREEN : C_GRAY;
      default: colour = C_GRAY;
    endcase
  end

  always_comb begin
    href_d = (state_d == S_ACTIVE) && (byte_d < 11'(ACTIVE_BYTES));
    d_d    = '0;
    if (href_d) begin
      case (byte_d[1:0])
        2'd0:    d_d = colour.cb;
        2'd2:    d_d = colour.cr;
        default: d_d = colour.y;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK_24) begin
    if (reset) begin
      pclk_q      <= 1'b0;
      state_q     <= S_IDLE;
      byte_q      <= '0;
      line_q      <= '0;
      pat_q       <= '0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      VSYNC       <= 1'b0;
      HREF        <= 1'b0;
      D           <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pclk_q      <= ~pclk_q;
      frame_start <= slot && start_frame;
      if (slot) begin
        state_q <= state_d;
        byte_q  <= byte_d;
        line_q  <= line_d;
        VSYNC   <= (state_d == S_VSYNC);
        HREF    <= href_d;
        D       <= d_d;
        busy    <= (state_d != S_IDLE);
        if (start_frame) begin
          pat_q   <= pattern_sel;
          box_x_q <= box_x;
          box_y_q <= box_y;
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_emulator.sv
// Directed bench for ov7670_emulator: a reduced-geometry instance for frame
// timing, parameter latching, box clipping, enable drop and reset, and a
// full-width instance for the colour-bar byte stream.
module tb_ov7670_emulator;

  localparam int HA    = 16;
  localparam int HB    = 8;
  localparam int VS    = 3;
  localparam int VB    = 2;
  localparam int VA    = 8;
  localparam int VF    = 2;
  localparam int BOX   = 4;
  localparam int LB    = 2 * HA + HB;
  localparam int FRAME = (VS + VB + VA + VF) * LB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic [9:0] box_x = 10'd0;
  logic [9:0] box_y = 10'd0;
  logic       pclk, vsync, href, fs, busy;
  logic [7:0] d;

  logic       b_enable = 1'b0;
  logic       b_pclk, b_vsync, b_href, b_fs, b_busy;
  logic [7:0] b_d;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ov7670_emulator #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK_BYTES(HB), .V_SYNC_LINES(VS),
    .V_BACK_LINES(VB), .V_FRONT_LINES(VF), .BOX_SIZE(BOX)
  ) dut (
    .CLOCK_24(clk), .reset(reset), .enable(enable), .pattern_sel(pattern_sel),
    .box_x(box_x), .box_y(box_y), .PCLK(pclk), .VSYNC(vsync), .HREF(href),
    .D(d), .frame_start(fs), .busy(busy)
  );

  ov7670_emulator #(
    .V_ACTIVE(2), .V_SYNC_LINES(1), .V_BACK_LINES(1), .V_FRONT_LINES(1)
  ) dut_bars (
    .CLOCK_24(clk), .reset(reset), .enable(b_enable), .pattern_sel(2'd1),
    .box_x(10'd0), .box_y(10'd0), .PCLK(b_pclk), .VSYNC(b_vsync), .HREF(b_href),
    .D(b_d), .frame_start(b_fs), .busy(b_busy)
  );

  // Per-frame record filled by run_frame.
  int r_vs, r_href_pulses, r_len_bad, r_first_href, r_periods;
  int r_blank_bad, r_fs, r_end_vsync, r_end_idle;
  logic [7:0] act_d [VA][2*HA];

  function automatic logic [7:0] exp_box(input int line, input int b);
    int x, sel, px;
    logic green;
    x     = (b / 4) * 2;
    sel   = b % 4;
    px    = (sel == 3) ? x + 1 : x;
    green = (px >= 13) && (px < 13 + BOX) && (line >= 6) && (line < 6 + BOX);
    if (sel == 0)      exp_box = green ? 8'd44 : 8'd128;
    else if (sel == 2) exp_box = green ? 8'd21 : 8'd128;
    else               exp_box = green ? 8'd150 : 8'd128;
  endfunction

  // Starts at the negedge where VSYNC was first seen high; records one frame.
  task automatic run_frame(input int drop_line, input logic chg,
                           input logic [1:0] new_pat, input logic [9:0] nbx,
                           input logic [9:0] nby);
    int period, cur_line, byte_i;
    logic prev_vs, prev_href;
    r_vs = 0; r_href_pulses = 0; r_len_bad = 0; r_first_href = -1;
    r_blank_bad = 0; r_fs = 0; r_end_vsync = 0; r_end_idle = 0;
    for (int l = 0; l < VA; l++)
      for (int b = 0; b < 2 * HA; b++) act_d[l][b] = 8'h00;
    period = 0; cur_line = -1; byte_i = 0; prev_vs = 1'b1; prev_href = 1'b0;
    for (int c = 0; c < 4 * FRAME; c++) begin
      @(negedge clk);
      if (vsync && !prev_vs) begin r_end_vsync = 1; break; end
      if (!busy) begin r_end_idle = 1; break; end
      prev_vs = vsync;
      if (fs) r_fs++;
      if (pclk) begin
        if (vsync) r_vs++;
        if (href && !prev_href) begin
          r_href_pulses++;
          cur_line++;
          byte_i = 0;
          if (r_first_href < 0) r_first_href = period;
          if (chg && cur_line == 0) begin
            pattern_sel = new_pat; box_x = nbx; box_y = nby;
          end
          if (cur_line == drop_line) enable = 1'b0;
        end
        if (href) begin
          if (cur_line >= 0 && cur_line < VA && byte_i < 2 * HA) act_d[cur_line][byte_i] = d;
          byte_i++;
        end
        if (!href && prev_href && byte_i != 2 * HA) r_len_bad++;
        if (!href && d !== 8'h00) r_blank_bad++;
        prev_href = href;
        period++;
      end
    end
    r_periods = period;
  endtask

  task automatic test_reset();
    int toggles, bad;
    logic prev;
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pclk, vsync, href, d, fs, busy} !== 13'b0) begin
      n_err++;
      $display("FAIL reset_values: got pclk=%b vs=%b href=%b d=%h fs=%b busy=%b, want all 0",
               pclk, vsync, href, d, fs, busy);
    end
    reset = 1'b0;
    toggles = 0; bad = 0; prev = pclk;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pclk !== prev) toggles++;
      prev = pclk;
      if ({vsync, href, d, fs, busy} !== 12'b0) bad++;
    end
    n_cmp++;
    if (toggles != 1000) begin
      n_err++; $display("FAIL idle_pclk_toggles: got %0d want 1000", toggles);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL idle_outputs_quiet: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_start_latency();
    int lat;
    pattern_sel = 2'd3; box_x = 10'd0; box_y = 10'd0;
    enable = 1'b1;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (vsync) begin lat = k; break; end
    end
    n_cmp++;
    if (lat < 1 || lat > 2) begin
      n_err++; $display("FAIL start_latency: got %0d cycles want 1..2", lat);
    end
    n_cmp++;
    if (fs !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL start_flags: got fs=%b busy=%b want 1 1", fs, busy);
    end
  endtask

  task automatic test_geometry();
    int gray_bad;
    run_frame(-1, 1'b0, 2'd0, 10'd0, 10'd0);
    n_cmp++;
    if (r_end_vsync != 1 || r_periods != FRAME) begin
      n_err++; $display("FAIL frame_length: got %0d periods (vsync_end=%0d) want %0d",
                        r_periods, r_end_vsync, FRAME);
    end
    n_cmp++;
    if (r_vs != VS * LB) begin
      n_err++; $display("FAIL vsync_width: got %0d want %0d", r_vs, VS * LB);
    end
    n_cmp++;
    if (r_href_pulses != VA || r_len_bad != 0) begin
      n_err++; $display("FAIL href_pulses: got %0d pulses, %0d wrong length, want %0d, 0",
                        r_href_pulses, r_len_bad, VA);
    end
    n_cmp++;
    if (r_first_href != (VS + VB) * LB) begin
      n_err++; $display("FAIL href_offset: got %0d want %0d", r_first_href, (VS + VB) * LB);
    end
    n_cmp++;
    if (r_blank_bad != 0 || r_fs != 0) begin
      n_err++; $display("FAIL blank_d_and_fs: got %0d nonzero blank bytes, %0d extra fs, want 0 0",
                        r_blank_bad, r_fs);
    end
    gray_bad = 0;
    for (int l = 0; l < VA; l++)
      for (int b = 0; b < 2 * HA; b++) if (act_d[l][b] !== 8'h80) gray_bad++;
    n_cmp++;
    if (gray_bad != 0) begin
      n_err++; $display("FAIL gray_bytes: got %0d non-0x80 bytes want 0", gray_bad);
    end
    n_cmp++;
    if (fs !== 1'b1) begin
      n_err++; $display("FAIL back_to_back_fs: got %b want 1", fs);
    end
  endtask

  task automatic test_param_latch();
    int gray_bad;
    run_frame(-1, 1'b1, 2'd2, 10'd13, 10'd6);
    gray_bad = 0;
    for (int l = 0; l < VA; l++)
      for (int b = 0; b < 2 * HA; b++) if (act_d[l][b] !== 8'h80) gray_bad++;
    n_cmp++;
    if (r_end_vsync != 1 || r_href_pulses != VA || gray_bad != 0) begin
      n_err++; $display("FAIL param_latch: got end=%0d pulses=%0d changed_bytes=%0d want 1 %0d 0",
                        r_end_vsync, r_href_pulses, gray_bad, VA);
    end
  endtask

  task automatic test_box_clip();
    logic [7:0] want;
    run_frame(3, 1'b0, 2'd0, 10'd0, 10'd0);
    for (int l = 0; l < VA; l++)
      for (int b = 0; b < 2 * HA; b++) begin
        want = exp_box(l, b);
        n_cmp++;
        if (act_d[l][b] !== want) begin
          n_err++; $display("FAIL box_byte line %0d byte %0d: got %0d want %0d",
                            l, b, act_d[l][b], want);
        end
      end
  endtask

  task automatic test_enable_drop();
    int bad;
    n_cmp++;
    if (r_end_idle != 1 || r_periods != FRAME || r_href_pulses != VA || r_fs != 0) begin
      n_err++; $display("FAIL enable_drop_frame: got idle_end=%0d periods=%0d pulses=%0d fs=%0d want 1 %0d %0d 0",
                        r_end_idle, r_periods, r_href_pulses, r_fs, FRAME, VA);
    end
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (fs || vsync || busy || href) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL enable_drop_idle: got %0d active cycles want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int lines, bytes, lat, found;
    logic prev;
    enable = 1'b1;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (vsync) begin found = 1; break; end
    end
    lines = -1; bytes = 0; prev = 1'b0;
    if (found == 1) begin
      found = 0;
      for (int c = 0; c < 4 * FRAME; c++) begin
        @(negedge clk);
        if (pclk) begin
          if (href && !prev) begin lines++; bytes = 0; end
          if (href) bytes++;
          prev = href;
          if (lines == 2 && bytes == 11) begin found = 1; break; end
        end
      end
    end
    n_cmp++;
    if (found != 1 || href !== 1'b1 || d !== 8'h80) begin
      n_err++; $display("FAIL mid_reset_pre: got found=%0d href=%b d=%h want 1 1 80", found, href, d);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({pclk, vsync, href, d, fs, busy} !== 13'b0) begin
      n_err++; $display("FAIL mid_reset_values: got pclk=%b vs=%b href=%b d=%h fs=%b busy=%b want all 0",
                        pclk, vsync, href, d, fs, busy);
    end
    reset = 1'b0;
    lat = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (vsync) begin lat = k; break; end
    end
    n_cmp++;
    if (lat < 1 || lat > 2) begin
      n_err++; $display("FAIL restart_latency: got %0d want 1..2", lat);
    end
    enable = 1'b0;
  endtask

  task automatic test_bars();
    int bar_idx [28] = '{0, 1, 2, 3, 316, 317, 318, 319, 320, 321, 322, 323,
                         640, 641, 642, 643, 956, 957, 958, 959, 960, 961, 962, 963,
                         1276, 1277, 1278, 1279};
    int bar_val [28] = '{85, 76, 255, 76, 85, 76, 255, 76, 44, 150, 21, 150,
                         1, 226, 149, 226, 1, 226, 149, 226, 255, 29, 107, 29,
                         255, 29, 107, 29};
    logic [7:0] line0 [1280];
    logic [7:0] after_d;
    int idx, found;
    b_enable = 1'b1;
    found = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (b_vsync) begin found = 1; break; end
    end
    for (int i = 0; i < 1280; i++) line0[i] = 8'h00;
    idx = 0; after_d = 8'hff;
    if (found == 1) begin
      found = 0;
      for (int c = 0; c < 4 * 1568 * 2; c++) begin
        @(negedge clk);
        if (b_pclk) begin
          if (b_href) begin
            if (idx < 1280) line0[idx] = b_d;
            idx++;
          end else if (idx > 0) begin
            after_d = b_d; found = 1; break;
          end
        end
      end
    end
    b_enable = 1'b0;
    n_cmp++;
    if (found != 1 || idx != 1280 || after_d !== 8'h00) begin
      n_err++; $display("FAIL bars_line: got found=%0d href_len=%0d blank_d=%0d want 1 1280 0",
                        found, idx, after_d);
    end
    for (int i = 0; i < 28; i++) begin
      n_cmp++;
      if (line0[bar_idx[i]] !== 8'(bar_val[i])) begin
        n_err++; $display("FAIL bars_byte %0d: got %0d want %0d", bar_idx[i], line0[bar_idx[i]], bar_val[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_latency();
    test_geometry();
    test_param_latch();
    test_box_clip();
    test_enable_drop();
    test_mid_reset();
    test_bars();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
